// File: rtl/sram_req_ctrl_pkg.sv
// Shared types and constants for the SRAM request front-end.
// The command word carries everything needed to issue one SRAM access.
package sram_ctrl_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 256;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sram_cmd_t;

    // Bits needed to hold an occupancy count from 0 to depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request, response and SRAM-side signals of the request front-end.
// slave is the controller view, master is the requester/SRAM view.
interface sram_req_ctrl_if import sram_ctrl_pkg::*; #(
    parameter int RSP_DEPTH = 4
);

    logic                        req_valid;
    logic                        req_ready;
    logic                        req_we;
    logic [ADDR_W-1:0]           req_addr;
    logic [DATA_W-1:0]           req_wdata;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [DATA_W-1:0]           rsp_rdata;
    logic [ADDR_W-1:0]           sram_addr;
    logic [DATA_W-1:0]           sram_din;
    logic                        sram_we;
    logic [DATA_W-1:0]           sram_dout;
    logic                        valid_tx;
    logic [cnt_w(RSP_DEPTH)-1:0] rd_inflight;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_dout,
        output req_ready, rsp_valid, rsp_rdata, sram_addr, sram_din, sram_we,
               valid_tx, rd_inflight
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_dout,
        input  req_ready, rsp_valid, rsp_rdata, sram_addr, sram_din, sram_we,
               valid_tx, rd_inflight
    );

endinterface

// File: rtl/sram_req_ctrl_chk.sv
// Protocol checks for the request front-end FIFOs.
// A push into a full FIFO means a lost command or lost read data.
module sram_req_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic cmd_push_i,
    input logic cmd_full_i,
    input logic rsp_push_i,
    input logic rsp_full_i
);

    // Overflow checks, suppressed while reset is applied.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(cmd_push_i && cmd_full_i));
            assert (!(rsp_push_i && rsp_full_i));
        end
    end

endmodule

// File: rtl/sram_sync_fifo.sv
// Synchronous FIFO with separate occupancy count; pointers wrap modulo DEPTH.
// Pushes on full and pops on empty are ignored, so count only moves on legal operations.
module sram_sync_fifo import sram_ctrl_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == CW'(0));
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];

    // Next pointer and occupancy values.
    always_comb begin
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/sram_req_ctrl.sv
// In-order SRAM request front-end: command FIFO, credit-checked issue,
// RD_LAT read tag pipe and response FIFO.
module sram_req_ctrl import sram_ctrl_pkg::*; #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int RD_LAT    = 1
) (
    input logic            clk,
    input logic            rst,
    sram_req_ctrl_if.slave bus
);

    localparam int CCW = cnt_w(CMD_DEPTH);
    localparam int RCW = cnt_w(RSP_DEPTH);

    sram_cmd_t         cmd_in_s, cmd_head_s;
    logic              cmd_push_s, cmd_pop_s, cmd_full_s, cmd_empty_s;
    logic [CCW-1:0]    cmd_count_s;
    logic [DATA_W-1:0] rsp_head_s;
    logic              rsp_pop_s, rsp_full_s, rsp_empty_s;
    logic [RCW-1:0]    rsp_count_s;
    logic              req_ready_s, credit_ok_s, issue_s, issue_rd_s, capture_s;
    logic [RCW:0]      credit_sum_s;

    logic              rst_q;
    logic              sram_we_q, valid_tx_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_din_q;
    logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic [RCW-1:0]    rd_inflight_q, rd_inflight_d;

    assign cmd_in_s    = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
    assign req_ready_s = !rst_q && (cmd_count_s < CCW'(CMD_DEPTH));
    assign cmd_push_s  = bus.req_valid && req_ready_s;

    // Reads need a guaranteed slot in the response FIFO; a same-cycle pop earns no credit.
    assign credit_sum_s = {1'b0, rsp_count_s} + {1'b0, rd_inflight_q};
    assign credit_ok_s  = (credit_sum_s < (RCW+1)'(RSP_DEPTH));
    assign issue_s      = !cmd_empty_s && (cmd_head_s.we || credit_ok_s);
    assign issue_rd_s   = issue_s && !cmd_head_s.we;
    assign cmd_pop_s    = issue_s;
    assign capture_s    = rd_pipe_q[RD_LAT-1];
    assign rsp_pop_s    = !rsp_empty_s && bus.rsp_ready;

    sram_sync_fifo #(
        .WIDTH ($bits(sram_cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_push_s),
        .data_i  (cmd_in_s),
        .pop_i   (cmd_pop_s),
        .data_o  (cmd_head_s),
        .full_o  (cmd_full_s),
        .empty_o (cmd_empty_s),
        .count_o (cmd_count_s)
    );

    sram_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (capture_s),
        .data_i  (bus.sram_dout),
        .pop_i   (rsp_pop_s),
        .data_o  (rsp_head_s),
        .full_o  (rsp_full_s),
        .empty_o (rsp_empty_s),
        .count_o (rsp_count_s)
    );

    // Read tag pipe shift and in-flight read count.
    always_comb begin
        rd_pipe_d    = rd_pipe_q;
        rd_pipe_d[0] = issue_rd_s;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
        case ({issue_rd_s, capture_s})
            2'b10:   rd_inflight_d = rd_inflight_q + RCW'(1);
            2'b01:   rd_inflight_d = rd_inflight_q - RCW'(1);
            default: rd_inflight_d = rd_inflight_q;
        endcase
    end

    // Registered SRAM issue outputs, reset shadow and read tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q         <= 1'b1;
            sram_we_q     <= 1'b0;
            valid_tx_q    <= 1'b0;
            sram_addr_q   <= ADDR_W'(0);
            sram_din_q    <= DATA_W'(0);
            rd_pipe_q     <= RD_LAT'(0);
            rd_inflight_q <= RCW'(0);
        end else begin
            rst_q      <= 1'b0;
            sram_we_q  <= issue_s && cmd_head_s.we;
            valid_tx_q <= issue_s;
            if (issue_s) begin
                sram_addr_q <= cmd_head_s.addr;
                if (cmd_head_s.we) begin
                    sram_din_q <= cmd_head_s.wdata;
                end
            end
            rd_pipe_q     <= rd_pipe_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    assign bus.req_ready   = req_ready_s;
    assign bus.rsp_valid   = !rsp_empty_s;
    assign bus.rsp_rdata   = rsp_head_s;
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_din    = sram_din_q;
    assign bus.sram_we     = sram_we_q;
    assign bus.valid_tx    = valid_tx_q;
    assign bus.rd_inflight = rd_inflight_q;

    sram_req_ctrl_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .cmd_push_i (cmd_push_s),
        .cmd_full_i (cmd_full_s),
        .rsp_push_i (capture_s),
        .rsp_full_i (rsp_full_s)
    );

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Request front-end that sits directly upstream of the 256-bit SRAM port (15-bit address, single we, 1-cycle read latency).
- Accepts write/read commands over a valid/ready channel, buffers them in a command FIFO and issues at most one SRAM access per cycle.
- Captures read data into a response FIFO and returns it in order over a valid/ready channel.
- Drives the valid_tx monitor strobe consumed by the SRAM bus monitor.

Parameters:
ADDR_W, 15, SRAM word address width
DATA_W, 256, SRAM data width
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)
RD_LAT, 1, SRAM clk cycles from read issue to valid sram_dout (1..3)

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  command valid
req_ready  out  1  command FIFO can accept
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  read data available
rsp_ready  in  1  consumer accepts read data
rsp_rdata  out  DATA_W  read data, in issue order
sram_addr  out  ADDR_W  to SRAM addr
sram_din  out  DATA_W  to SRAM din
sram_we  out  1  to SRAM we
sram_dout  in  DATA_W  from SRAM dout
valid_tx  out  1  high on every issue cycle (monitor strobe)
rd_inflight  out  $clog2(RSP_DEPTH+1)  reads issued but not yet captured

Behaviour:
- Reset (rst=1 at posedge): both FIFOs emptied, inflight pipe cleared. Outputs: req_ready=0 during reset, then 1; rsp_valid=0; sram_we=0; valid_tx=0; sram_addr=0; sram_din=0; rd_inflight=0. Mid-operation reset drops queued commands and in-flight reads; read data returning after reset is discarded.
- Accept: handshake on req_valid&&req_ready. req_ready = !rst_q && cmd_count<CMD_DEPTH; it does not depend on same-cycle pop (no full-pass-through).
- Issue: the FIFO head is issued in the cycle after it is written, at the earliest. Issue condition: cmd FIFO non-empty AND (head is write OR rsp_count + rd_inflight < RSP_DEPTH). A same-cycle rsp pop is not credited (conservative). A stalled read blocks later writes; strict in-order.
- Issue outputs are registered: on the issue cycle sram_addr/sram_din/sram_we/valid_tx update at the next posedge and hold for exactly one cycle. Then sram_we=0 and valid_tx=0. sram_addr/sram_din hold their last values when idle. For a read, sram_din holds its previous value.
- Read capture: issued reads enter an RD_LAT-deep tag shift pipe. sram_dout is sampled RD_LAT cycles after sram_addr is driven and pushed into the rsp FIFO. The credit check guarantees the push never overflows; an overflow is an assertion failure.
- Latency (RD_LAT=1, empty queues): read accepted at edge t -> sram_addr driven after t+1 -> data captured at t+2 -> rsp_valid=1 after t+2 (3 cycles from accept). Write accepted at t -> sram_we=1 for cycle t+1..t+2.
- Throughput: 1 command/cycle sustained while credits allow.
- Write-then-read to the same address is issued in program order, so the read returns the new data.
- Response: rsp_rdata/rsp_valid come from the FIFO head (registered output). Pop on rsp_valid&&rsp_ready. rsp_valid stays asserted and rsp_rdata stays stable until accepted.
- rd_inflight increments on read issue and decrements on capture; both in the same cycle leaves it unchanged.
- FIFO pointers wrap modulo depth, with count held separately. Simultaneous push and pop on a full or empty FIFO keeps the count unchanged only where both operations are legal.

Decomposition:
- Package sram_ctrl_pkg: ADDR_W/DATA_W constants, typedef struct packed sram_cmd_t {we, addr, wdata}, and a localparam function for the count width.
- Sub-module sram_sync_fifo: parameterised width/depth, sync active-high rst, push/pop/full/empty/count, registered head output. Instantiated twice, once as cmd (sram_cmd_t) and once as rsp (DATA_W).
- Issue logic, credit check and RD_LAT tag pipe live in sram_req_ctrl.

Test Plan:
- Reset: hold rst 3 cycles with req_valid=1 -> req_ready=0, sram_we=0, valid_tx=0, rsp_valid=0; first accept occurs the cycle after rst deasserts.
- Single write then read: write 0x1234 <= {8{32'hDEADBEEF}}, then read 0x1234 -> one sram_we pulse at 0x1234, then rsp_rdata={8{32'hDEADBEEF}} exactly 3 cycles after the read accept.
- Back-to-back 8 writes then 8 reads to 0x0000..0x0007 (data=addr) with rsp_ready=1 -> valid_tx high 16 consecutive cycles after fill; responses 0..7 returned in order.
- Backpressure: rsp_ready=0, issue 10 reads -> exactly RSP_DEPTH reads issued, rd_inflight+rsp_count never >4, req_ready=0 once cmd FIFO full. Release rsp_ready -> all 10 returned in order, no loss.
- Address wrap: write/read 0x7FFF and 0x0000 -> distinct data returned, no aliasing.
- Mid-op reset: assert rst while 2 reads are in flight and 3 commands are queued -> no rsp_valid after reset, rd_inflight=0, late sram_dout ignored.
